and_or_sched: RTL and testbench
===============================

AND_OR_SCHED -- requirements
Module: and_or_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; the only supported value is 4.
REQ-002 Parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port req  input  4  level request, bit i = requester i.
REQ-006 Port op  input  16  operands; requester i drives op[4i+3:4i] = {A,B,C,D}, A is the MSB.
REQ-007 Port sop_a, sop_b, sop_c, sop_d  output  1 each  registered operands driven to the shared AND-OR unit.
REQ-008 Port sop_y  input  1  result returned by the shared unit, Y = (A&B)|(C&D), combinational.
REQ-009 Port gnt  output  4  one-hot grant, high for exactly one cycle per transaction.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port y  output  1  captured result, held until the next capture.
REQ-012 Port y_id  output  2  index of the requester that owns y.
REQ-013 Port y_valid  output  1  one-cycle pulse when y and y_id are new.
REQ-014 Port cnt  output  CNT_W  number of completed transactions, modulo 2^CNT_W.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-016 In IDLE with req==0, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-017 In IDLE with req!=0, the winner SHALL be the first set bit when searching from pointer p through p+1, p+2, p+3 (mod 4).
REQ-018 On the IDLE-to-ISSUE edge, the block SHALL latch the winner's nibble into sop_a..sop_d, latch the winner index, and set gnt to onehot(winner).
REQ-019 Operands SHALL be sampled only on the IDLE-to-ISSUE edge; op changes in ISSUE or DONE SHALL have no effect.
REQ-020 In ISSUE, gnt SHALL be high and sop_a..sop_d SHALL be stable.
REQ-021 At the end of ISSUE, the block SHALL capture sop_y into y, load y_id, set y_valid=1, clear gnt and enter DONE.
REQ-022 In DONE, y_valid SHALL be high; at the end of DONE, the block SHALL clear y_valid, set p = winner+1 mod 4 (3 wraps to 0), increment cnt (wrapping to 0) and return to IDLE.
REQ-023 Latency: a request sampled in IDLE at edge T SHALL give gnt in cycle T+1 and y_valid in cycle T+2.
REQ-024 The earliest next grant SHALL appear in cycle T+4, giving a throughput of one transaction per 3 cycles.
REQ-025 A req bit still high after its grant SHALL re-enter arbitration; round-robin order SHALL give it the lowest priority next time.
REQ-026 A req bit deasserted during ISSUE or DONE SHALL NOT abort the transaction in progress.
REQ-027 Simultaneous requests SHALL produce exactly one grant; gnt SHALL never have more than one bit set.
REQ-028 sop_a..sop_d SHALL hold their last values outside ISSUE.

Reset
REQ-029 When rst_n==0 at a rising edge, in any state including mid-transaction, the next state SHALL be IDLE.
REQ-030 On that reset edge, the block SHALL set gnt=0, y_valid=0, y=0, y_id=0, sop_a..sop_d=0, cnt=0 and p=0.
REQ-031 A transaction interrupted by reset SHALL produce no y_valid pulse and SHALL NOT increment cnt.
REQ-032 While rst_n==0, req SHALL be ignored; arbitration SHALL start on the first edge with rst_n==1.

Verification
REQ-033 Reset: rst_n=0 for 2 cycles with req=4'hF -> gnt=0, busy=0, y_valid=0, cnt=0 throughout.
REQ-034 Single request: req=0001 with op[3:0]=0111 -> gnt=0001 in T+1, y_valid in T+2 with y=1, y_id=0.
REQ-035 Zero result: requester 0 with op[3:0]=0010 -> y=0, and cnt increments.
REQ-036 Fairness and wrap: req=1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
REQ-037 Reset mid-operation: rst_n=0 during ISSUE -> no y_valid pulse, cnt unchanged at 0; then req=0100 -> gnt=0100, y_id=2.
REQ-038 Counter wrap: 256 back-to-back transactions -> cnt returns to 0; each y equals (A&B)|(C&D) of the granted nibble, checked with the bench's AND-OR instance on sop_*/sop_y.

Source files
------------

// File: rtl/and_or_sched_if.sv
// Bundle between the round-robin AND-OR scheduler and the requesters plus the shared
// AND-OR unit. The slave side is the scheduler; the master side drives requests and sop_y.
interface and_or_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] op;
    logic               sop_a;
    logic               sop_b;
    logic               sop_c;
    logic               sop_d;
    logic               sop_y;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               y;
    logic [1:0]         y_id;
    logic               y_valid;
    logic [CNT_W-1:0]   cnt;

    modport master (
        output req, op, sop_y,
        input  sop_a, sop_b, sop_c, sop_d, gnt, busy, y, y_id, y_valid, cnt
    );

    modport slave (
        input  req, op, sop_y,
        output sop_a, sop_b, sop_c, sop_d, gnt, busy, y, y_id, y_valid, cnt
    );
endinterface

// File: rtl/and_or_sched.sv
// Round-robin scheduler sharing one combinational AND-OR unit among four requesters;
// one transaction every three cycles (IDLE -> ISSUE -> DONE).
module and_or_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    and_or_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t             state_reg;
    logic [1:0]         ptr_reg;
    logic [1:0]         win_idx_reg;
    logic [3:0]         sop_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic               busy_reg;
    logic               y_reg;
    logic [1:0]         y_id_reg;
    logic               y_valid_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [3:0]         nibble [N_REQ];
    logic [N_REQ-1:0]   rot_req;
    logic [1:0]         win_ofs;
    logic [1:0]         win_next;
    logic [N_REQ-1:0]   gnt_next;

    // rot_req[0] is the requester at the pointer, so the lowest set bit is the winner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign nibble[gi]  = bus.op[4*gi +: 4];
            assign rot_req[gi] = bus.req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        win_ofs = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_ofs = 2'(k);
            end
        end
        win_next = ptr_reg + win_ofs;
        gnt_next = N_REQ'(1) << win_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            win_idx_reg <= '0;
            sop_reg     <= '0;
            gnt_reg     <= '0;
            busy_reg    <= 1'b0;
            y_reg       <= 1'b0;
            y_id_reg    <= '0;
            y_valid_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|bus.req) begin
                        sop_reg     <= nibble[win_next];
                        win_idx_reg <= win_next;
                        gnt_reg     <= gnt_next;
                        busy_reg    <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    y_reg       <= bus.sop_y;
                    y_id_reg    <= win_idx_reg;
                    y_valid_reg <= 1'b1;
                    gnt_reg     <= '0;
                    state_reg   <= DONE;
                end
                DONE: begin
                    // Pointer moves past the winner so it gets lowest priority next round.
                    y_valid_reg <= 1'b0;
                    ptr_reg     <= win_idx_reg + 2'd1;
                    cnt_reg     <= cnt_reg + 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.sop_a   = sop_reg[3];
    assign bus.sop_b   = sop_reg[2];
    assign bus.sop_c   = sop_reg[1];
    assign bus.sop_d   = sop_reg[0];
    assign bus.gnt     = gnt_reg;
    assign bus.busy    = busy_reg;
    assign bus.y       = y_reg;
    assign bus.y_id    = y_id_reg;
    assign bus.y_valid = y_valid_reg;
    assign bus.cnt     = cnt_reg;
endmodule

// File: tb/tb_and_or_sched.sv
// Bench for and_or_sched: transaction-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_and_or_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    and_or_sched_if #(.N_REQ(4), .CNT_W(8)) bus ();

    and_or_sched #(.N_REQ(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared AND-OR unit
    assign bus.sop_y = (bus.sop_a & bus.sop_b) | (bus.sop_c & bus.sop_d);

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: age of the in-flight transaction (0 = none, 1 = granted, 2 = result out)
    int m_age = 0, m_win = 0, m_ptr = 0, m_nib = 0;
    int m_y = 0, m_yid = 0, m_cnt = 0;
    bit m_known = 0;

    function automatic int exp_gnt();
        return (m_age == 1) ? (1 << m_win) : 0;
    endfunction
    function automatic int exp_busy();
        return (m_age != 0) ? 1 : 0;
    endfunction
    function automatic int exp_yv();
        return (m_age == 2) ? 1 : 0;
    endfunction

    task automatic note(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic lit(input string name, input int dut_v, input int mod_v, input int want);
        note({name, " dut"}, dut_v, want);
        note({name, " model"}, mod_v, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_age = 0; m_win = 0; m_ptr = 0; m_nib = 0;
                m_y = 0; m_yid = 0; m_cnt = 0; m_known = 1;
            end else if (m_age == 0) begin
                if (bus.req != 0) begin
                    for (int k = 3; k >= 0; k--) begin
                        if (bus.req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
                    end
                    m_nib = int'(bus.op[4*m_win +: 4]);
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                m_y   = (((m_nib >> 3) & (m_nib >> 2)) | ((m_nib >> 1) & m_nib)) & 1;
                m_yid = m_win;
                m_age = 2;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
                m_ptr = (m_win + 1) % 4;
                m_age = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                note("gnt", int'(bus.gnt), exp_gnt());
                note("busy", int'(bus.busy), exp_busy());
                note("y_valid", int'(bus.y_valid), exp_yv());
                note("y", int'(bus.y), m_y);
                note("y_id", int'(bus.y_id), m_yid);
                note("cnt", int'(bus.cnt), m_cnt);
                note("sop", int'({bus.sop_a, bus.sop_b, bus.sop_c, bus.sop_d}), m_nib);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before 1000000");
        $fatal(1);
    end

    initial begin
        int gseq[5];
        int gcyc[5];
        int ng;

        rst_n   = 1'b0;
        bus.req = 4'hF;
        bus.op  = 16'($urandom);
        repeat (2) begin
            tick();
            lit("rst gnt", int'(bus.gnt), exp_gnt(), 0);
            lit("rst busy", int'(bus.busy), exp_busy(), 0);
            lit("rst y_valid", int'(bus.y_valid), exp_yv(), 0);
            lit("rst cnt", int'(bus.cnt), m_cnt, 0);
        end

        // Single request, result 1
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        bus.op  = 16'h0007;
        tick();
        lit("single gnt", int'(bus.gnt), exp_gnt(), 1);
        lit("single busy", int'(bus.busy), exp_busy(), 1);
        bus.req = 4'b0000;
        bus.op  = 16'hFFF0;
        tick();
        lit("single y_valid", int'(bus.y_valid), exp_yv(), 1);
        lit("single y", int'(bus.y), m_y, 1);
        lit("single y_id", int'(bus.y_id), m_yid, 0);
        lit("single gnt off", int'(bus.gnt), exp_gnt(), 0);
        tick();
        lit("single cnt", int'(bus.cnt), m_cnt, 1);
        lit("single busy off", int'(bus.busy), exp_busy(), 0);

        // Zero result
        bus.req = 4'b0001;
        bus.op  = (16'($urandom) & 16'hFFF0) | 16'h0002;
        tick();
        lit("zero gnt", int'(bus.gnt), exp_gnt(), 1);
        bus.req = 4'b0000;
        tick();
        lit("zero y", int'(bus.y), m_y, 0);
        lit("zero y_valid", int'(bus.y_valid), exp_yv(), 1);
        tick();
        lit("zero cnt", int'(bus.cnt), m_cnt, 2);

        // Fairness and wrap with all requests held
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.req = 4'hF;
        ng = 0;
        for (int c = 0; c < 20 && ng < 5; c++) begin
            bus.op = 16'($urandom);
            tick();
            if (bus.gnt != 0) begin
                gseq[ng] = int'(bus.gnt);
                gcyc[ng] = c;
                ng++;
            end
        end
        note("fair grant count", ng, 5);
        for (int i = 0; i < ng; i++) begin
            note("fair gnt", gseq[i], 1 << (i % 4));
            if (i > 0) note("fair spacing", gcyc[i] - gcyc[i-1], 3);
        end

        // Reset during ISSUE
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.req = 4'hF;
        tick();
        lit("midrst issue gnt", int'(bus.gnt), exp_gnt(), 1);
        rst_n = 1'b0;
        tick();
        lit("midrst gnt", int'(bus.gnt), exp_gnt(), 0);
        lit("midrst busy", int'(bus.busy), exp_busy(), 0);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        tick();
        lit("midrst y_valid", int'(bus.y_valid), exp_yv(), 0);
        lit("midrst cnt", int'(bus.cnt), m_cnt, 0);
        bus.req = 4'b0100;
        tick();
        lit("after rst gnt", int'(bus.gnt), exp_gnt(), 4);
        bus.req = 4'b0000;
        tick();
        lit("after rst y_id", int'(bus.y_id), m_yid, 2);
        lit("after rst y_valid", int'(bus.y_valid), exp_yv(), 1);
        tick();

        // 256 back-to-back transactions wrap the counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 768; i++) begin
            bus.req = 4'($urandom_range(1, 15));
            bus.op  = 16'($urandom);
            tick();
            if (i == 764) lit("wrap cnt 255", int'(bus.cnt), m_cnt, 255);
        end
        lit("wrap cnt 0", int'(bus.cnt), m_cnt, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            bus.req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            bus.op  = 16'($urandom);
            rst_n   = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst_n   = 1'b1;
        bus.req = 4'h0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
